// File: rtl/fetch_if_stage.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register, stall/flush/drain handling.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic [DATA_WIDTH-1:0] PCPlus4F,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  FetchStallF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  InstrMisalignD
);

  // state | meaning
  // ISSUE | presenting PCF to imem, nothing outstanding
  // WAIT  | request accepted, waiting for its response
  // DRAIN | outstanding response belongs to a flushed path, drop it
  // HOLD  | response captured in hold buffer while decode is stalled
  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pend_pc;
  logic [DATA_WIDTH-1:0] r_pend_pc4;
  logic [DATA_WIDTH-1:0] r_hold_instr;
  logic [DATA_WIDTH-1:0] r_instr_d;
  logic [DATA_WIDTH-1:0] r_pc_d;
  logic [DATA_WIDTH-1:0] r_pc4_d;
  logic                  r_valid_d;

  logic                  w_misalign;
  logic                  w_in_issue;
  logic                  w_req_valid;
  logic                  w_req_fire;
  logic                  w_wait_dlv;
  logic                  w_hold_dlv;
  logic                  w_mis_dlv;
  logic                  w_deliver;
  logic                  w_hold_load;
  logic [DATA_WIDTH-1:0] w_dlv_instr;
  logic [DATA_WIDTH-1:0] w_dlv_pc;
  logic [DATA_WIDTH-1:0] w_dlv_pc4;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign_d;
  assign w_misalign     = (PCF[1:0] != 2'b00);
  assign InstrMisalignD = r_misalign_d;
`else
  assign w_misalign     = 1'b0;
  assign InstrMisalignD = 1'b0;
`endif

  assign w_in_issue  = (r_state == S_ISSUE);
  assign w_req_valid = ~reset & w_in_issue & ~w_misalign;
  assign w_req_fire  = w_req_valid & imem_req_ready;

  assign w_wait_dlv  = (r_state == S_WAIT) & imem_rsp_valid & ~StallD & ~FlushD;
  assign w_hold_dlv  = (r_state == S_HOLD) & ~StallD & ~FlushD;
  assign w_mis_dlv   = w_in_issue & w_misalign & ~StallD & ~FlushD;
  assign w_deliver   = w_wait_dlv | w_hold_dlv | w_mis_dlv;
  assign w_hold_load = (r_state == S_WAIT) & imem_rsp_valid & StallD & ~FlushD;

  // PC advances once per delivered instruction, and on flush to take the target
  assign FetchStallF    = ~(w_deliver | FlushD);
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = PCF;

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc4_d;
  assign ValidD   = r_valid_d;

  always_comb begin
    w_dlv_instr = imem_rsp_data;
    w_dlv_pc    = r_pend_pc;
    w_dlv_pc4   = r_pend_pc4;
    if (r_state == S_HOLD) begin
      w_dlv_instr = r_hold_instr;
    end else if (w_in_issue) begin
      w_dlv_instr = NOP_INSTR;
      w_dlv_pc    = PCF;
      w_dlv_pc4   = PCPlus4F;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ISSUE: begin
        if (w_req_fire) w_state_nxt = FlushD ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (FlushD)              w_state_nxt = imem_rsp_valid ? S_ISSUE : S_DRAIN;
        else if (imem_rsp_valid) w_state_nxt = StallD ? S_HOLD : S_ISSUE;
      end
      S_DRAIN: begin
        if (imem_rsp_valid) w_state_nxt = S_ISSUE;
      end
      S_HOLD: begin
        if (FlushD || !StallD) w_state_nxt = S_ISSUE;
      end
      default: w_state_nxt = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ISSUE;
      r_pend_pc    <= '0;
      r_pend_pc4   <= '0;
      r_hold_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_pend_pc  <= PCF;
        r_pend_pc4 <= PCPlus4F;
      end
      if (w_hold_load) r_hold_instr <= imem_rsp_data;
    end
  end

  // IF/ID register: reset > flush > stall > deliver > bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (StallD) begin
      r_instr_d <= r_instr_d;
    end else if (w_deliver) begin
      r_instr_d <= w_dlv_instr;
      r_pc_d    <= w_dlv_pc;
      r_pc4_d   <= w_dlv_pc4;
      r_valid_d <= 1'b1;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || FlushD)   r_misalign_d <= 1'b0;
    else if (!StallD)      r_misalign_d <= w_mis_dlv;
  end
`endif

endmodule

// File: tb/tb_fetch_if_stage.sv
// Scoreboard bench for fetch_if_stage: directed imem traffic, expected IF/ID loads queued and
// checked by a monitor; covers FETCH_MISALIGN_CHECK_EN when that macro is defined.
module tb_fetch_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        StallD;
  logic        FlushD;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        FetchStallF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        InstrMisalignD;

  fetch_if_stage #(.DATA_WIDTH(32), .NOP_INSTR(32'h00000013)) dut (
    .clk            (clk),
    .reset          (reset),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .FetchStallF    (FetchStallF),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .InstrMisalignD (InstrMisalignD)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_armed = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic mis);
    exp_t x;
    x.instr = instr;
    x.pc    = pc;
    x.pc4   = pc4;
    x.valid = 1'b1;
    x.mis   = mis;
    q.push_back(x);
  endtask

  // A cycle with FetchStallF=0 and no flush is a delivery; the IF/ID load is visible one cycle later.
  always @(negedge clk) begin
    if (mon_armed) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: actual InstrD=%h PCD=%h required no delivery", InstrD, PCD);
      end else begin
        e = q.pop_front();
        chk("dlv_InstrD",   InstrD,                 e.instr);
        chk("dlv_PCD",      PCD,                    e.pc);
        chk("dlv_PCPlus4D", PCPlus4D,               e.pc4);
        chk("dlv_ValidD",   {31'd0, ValidD},        {31'd0, e.valid});
        chk("dlv_Misalign", {31'd0, InstrMisalignD}, {31'd0, e.mis});
      end
    end
    mon_armed = (reset === 1'b0) && (FetchStallF === 1'b0) && (FlushD === 1'b0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; PCF = 32'h0; PCPlus4F = 32'h4; StallD = 1'b0; FlushD = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    step(); step();
    chk("rst_ValidD",    {31'd0, ValidD},         32'd0);
    chk("rst_InstrD",    InstrD,                  NOP);
    chk("rst_PCD",       PCD,                     32'h0);
    chk("rst_PCPlus4D",  PCPlus4D,                32'h0);
    chk("rst_Misalign",  {31'd0, InstrMisalignD}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // basic fetch
    reset = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req_addr",  imem_req_addr,           32'h0);
    chk("t1_stall_iss", {31'd0, FetchStallF},    32'd1);
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
    push(32'h00500093, 32'h0, 32'h4, 1'b0);
    #1;
    chk("t1_stall_dlv", {31'd0, FetchStallF},    32'd0);
    chk("t1_req_wait",  {31'd0, imem_req_valid}, 32'd0);

    // response under decode stall goes to the hold buffer
    step();
    imem_rsp_valid = 1'b0; StallD = 1'b1; PCF = 32'h4; PCPlus4F = 32'h8; imem_req_ready = 1'b1;
    #1;
    chk("t2_stall_iss", {31'd0, FetchStallF}, 32'd1);
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h002081B3;
    #1;
    chk("t2_stall_rsp", {31'd0, FetchStallF}, 32'd1);
    chk("t2_instr_rsp", InstrD,               32'h00500093);
    step();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_hold_stall", {31'd0, FetchStallF}, 32'd1);
      chk("t2_hold_instr", InstrD,               32'h00500093);
      chk("t2_hold_valid", {31'd0, ValidD},      32'd1);
      step();
    end
    StallD = 1'b0;
    push(32'h002081B3, 32'h4, 32'h8, 1'b0);
    #1;
    chk("t2_release", {31'd0, FetchStallF}, 32'd0);
    step();

    // flush while waiting, late response dropped
    PCF = 32'h8; PCPlus4F = 32'hC; imem_req_ready = 1'b1;
    #1;
    chk("t3_stall_iss", {31'd0, FetchStallF}, 32'd1);
    step();
    imem_req_ready = 1'b0; FlushD = 1'b1;
    #1;
    chk("t3_flush_pc", {31'd0, FetchStallF}, 32'd0);
    step();
    FlushD = 1'b0; PCF = 32'h100; PCPlus4F = 32'h104;
    #1;
    chk("t3_fl_valid", {31'd0, ValidD},         32'd0);
    chk("t3_fl_instr", InstrD,                  NOP);
    chk("t3_drain_rq", {31'd0, imem_req_valid}, 32'd0);
    chk("t3_drain_st", {31'd0, FetchStallF},    32'd1);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    #1;
    chk("t3_drop_st", {31'd0, FetchStallF}, 32'd1);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t3_drop_valid", {31'd0, ValidD},         32'd0);
    chk("t3_drop_instr", InstrD,                  NOP);
    chk("t3_new_req",    {31'd0, imem_req_valid}, 32'd1);
    chk("t3_new_addr",   imem_req_addr,           32'h100);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100113;
    push(32'h00100113, 32'h100, 32'h104, 1'b0);
    step();
    imem_rsp_valid = 1'b0; PCF = 32'h104; PCPlus4F = 32'h108;

    // memory back-pressure
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t4_req_addr",  imem_req_addr,           32'h104);
      chk("t4_stall",     {31'd0, FetchStallF},    32'd1);
      step();
      chk("t4_bubble",    {31'd0, ValidD},         32'd0);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00208233;
    push(32'h00208233, 32'h104, 32'h108, 1'b0);
    step();
    imem_rsp_valid = 1'b0; PCF = 32'h108; PCPlus4F = 32'h10C;

    // flush and stall together in HOLD
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; StallD = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00310293;
    step();
    imem_rsp_valid = 1'b0; FlushD = 1'b1;
    #1;
    chk("t5_flush_st", {31'd0, FetchStallF}, 32'd0);
    step();
    FlushD = 1'b0; StallD = 1'b0; PCF = 32'h200; PCPlus4F = 32'h204;
    #1;
    chk("t5_valid", {31'd0, ValidD},         32'd0);
    chk("t5_instr", InstrD,                  NOP);
    chk("t5_req",   {31'd0, imem_req_valid}, 32'd1);
    chk("t5_addr",  imem_req_addr,           32'h200);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00400313;
    push(32'h00400313, 32'h200, 32'h204, 1'b0);
    step();
    imem_rsp_valid = 1'b0;

    // stray response with nothing outstanding
    PCF = 32'h204; PCPlus4F = 32'h208; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11111111;
    #1;
    chk("t6_stray_st", {31'd0, FetchStallF}, 32'd1);
    step();
    imem_rsp_valid = 1'b0;
    chk("t6_valid", {31'd0, ValidD}, 32'd0);
    chk("t6_instr", InstrD,          NOP);

    // PC+4 wrap
    PCF = 32'hFFFFFFFC; PCPlus4F = 32'h0; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000517;
    push(32'h00000517, 32'hFFFFFFFC, 32'h0, 1'b0);
    step();
    imem_rsp_valid = 1'b0;

    // reset with a request outstanding
    PCF = 32'h0; PCPlus4F = 32'h4; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h22222222;
    #1;
    chk("t8_rsp_st", {31'd0, FetchStallF}, 32'd1);
    chk("t8_pcd",    PCD,                  32'h0);
    step();
    imem_rsp_valid = 1'b0;
    chk("t8_valid", {31'd0, ValidD}, 32'd0);
    chk("t8_instr", InstrD,          NOP);

`ifdef FETCH_MISALIGN_CHECK_EN
    PCF = 32'h102; PCPlus4F = 32'h106; imem_req_ready = 1'b1;
    #1;
    chk("t9_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("t9_stall",  {31'd0, FetchStallF},    32'd0);
    push(NOP, 32'h102, 32'h106, 1'b1);
    step();
    PCF = 32'h104; PCPlus4F = 32'h108; imem_req_ready = 1'b0;
    #1;
    chk("t9_aligned_req", {31'd0, imem_req_valid}, 32'd1);
`endif

    step(); step(); step();
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
